// File: rtl/data_output.sv
// data_output: serial transmit path for audio words.
// The host pushes words into a FIFO with `load`. While `enable` is high the
// transmitter pops one word per 24-cycle slot and shifts it out LSB first on
// `serial`, one bit per clock. If a slot begins with the FIFO empty, a zero
// word is sent instead and the sticky `underrun` flag is set. `rpi_interrupt`
// asks the host for more data once the fill level falls to the low-water mark.
// It stays asserted, with hysteresis, until the FIFO is full again.
module data_output #(
    parameter int WORD_W    = 24,
    parameter int DEPTH     = 64,
    parameter int LOW_WATER = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data,
    input  logic              load,
    input  logic              enable,
    input  logic              underrun_clr,
    output logic              serial,
    output logic              word_start,
    output logic              rpi_interrupt,
    output logic              full,
    output logic              empty,
    output logic              underrun,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LOW_C      = CNT_W'(LOW_WATER);
    localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(WORD_W - 1);

    // FIFO state
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Transmitter state
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_shreg;
    logic              r_serial;
    logic              r_word_start;

    // Flags
    logic              r_irq;
    logic              r_underrun;
    logic              r_overflow;

    // Per-cycle decode
    logic              w_full;
    logic              w_empty;
    logic              w_slot;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [WORD_W-1:0] w_next_word;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A slot starts on every enabled cycle with bit_cnt at 0. That is the only
    // point where the FIFO is read, so there is at most one pop per word time.
    assign w_slot = enable && (r_bit_cnt == '0);
    assign w_pop  = w_slot && !w_empty;

    // A load into a full FIFO is still accepted if a pop frees a slot on the
    // same edge. A pop decision uses the pre-edge count, so a load into an
    // empty FIFO is never passed straight through to the transmitter.
    assign w_push = load && (!w_full || w_pop);
    assign w_drop = load && w_full && !w_pop;

    // Word that enters the shift register at a slot: the FIFO head, or zeros on underrun.
    assign w_next_word = w_pop ? r_mem[r_rd_ptr] : '0;

    // Write accepted words into the storage array.
    // NOTE: the storage array has no reset. A slot is never read before it
    // has been written, and a reset-free array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // Advance the pointers and track the fill level; the pointers wrap naturally.
    // NOTE: all clocked state uses non-blocking assignments, so every register
    // reads pre-edge values no matter what order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serialize: load a word at bit 0, then emit bits 1..WORD_W-1. Dropping
    // enable abandons the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_serial     <= 1'b0;
            r_word_start <= 1'b0;
        end else if (!enable) begin
            r_bit_cnt    <= '0;
            r_serial     <= 1'b0;
            r_word_start <= 1'b0;
        end else if (r_bit_cnt == '0) begin
            r_shreg      <= w_next_word;
            r_serial     <= w_next_word[0];
            r_word_start <= 1'b1;
            r_bit_cnt    <= BIT_W'(1);
        end else begin
            r_serial     <= r_shreg[r_bit_cnt];
            r_word_start <= 1'b0;
            r_bit_cnt    <= (r_bit_cnt == LAST_BIT_C) ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // Refill request with hysteresis: set at or below the low-water mark,
    // cleared only when the FIFO is full again or transmission stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (!enable || w_full) begin
            r_irq <= 1'b0;
        end else if (r_count <= LOW_C) begin
            r_irq <= 1'b1;
        end
    end

    // Sticky error flags. An underrun in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_slot && w_empty) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign serial        = r_serial;
    assign word_start    = r_word_start;
    assign rpi_interrupt = r_irq;
    assign full          = w_full;
    assign empty         = w_empty;
    assign underrun      = r_underrun;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_data_output.sv
// Testbench for data_output. A queue-based reference model predicts every
// output on every cycle. The directed scenarios also compare the serial
// stream against fixed words.
module tb_data_output;

    logic        clk;
    logic        rst_n;
    logic [23:0] data;
    logic        load;
    logic        enable;
    logic        underrun_clr;
    logic        serial;
    logic        word_start;
    logic        rpi_interrupt;
    logic        full;
    logic        empty;
    logic        underrun;
    logic        overflow;

    int total;
    int bad;

    data_output dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data         (data),
        .load         (load),
        .enable       (enable),
        .underrun_clr (underrun_clr),
        .serial       (serial),
        .word_start   (word_start),
        .rpi_interrupt(rpi_interrupt),
        .full         (full),
        .empty        (empty),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [23:0] m_q[$];
    logic [23:0] m_word;
    int          m_pos;
    logic        m_serial;
    logic        m_ws;
    logic        m_irq;
    logic        m_und;
    logic        m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_word   = '0;
        m_pos    = 0;
        m_serial = 0;
        m_ws     = 0;
        m_irq    = 0;
        m_und    = 0;
        m_ovf    = 0;
    endtask

    // One rising edge of the model, applied to the inputs sampled at that edge.
    task automatic model_step(input logic ld, input logic [23:0] d,
                              input logic en, input logic clr);
        int   cnt;
        logic pop;
        cnt = m_q.size();
        pop = en && (m_pos == 0) && (cnt > 0);
        if (!en || cnt == 64) m_irq = 0;
        else if (cnt <= 32)   m_irq = 1;
        if (en && m_pos == 0 && cnt == 0) m_und = 1;
        else if (clr)                     m_und = 0;
        if (en) begin
            if (m_pos == 0) begin
                m_word   = pop ? m_q.pop_front() : 24'h0;
                m_serial = m_word[0];
                m_ws     = 1;
                m_pos    = 1;
            end else begin
                m_serial = m_word[m_pos];
                m_ws     = 0;
                m_pos    = (m_pos + 1) % 24;
            end
        end else begin
            m_serial = 0;
            m_ws     = 0;
            m_pos    = 0;
        end
        if (ld) begin
            if (cnt < 64 || pop) m_q.push_back(d);
            else                 m_ovf = 1;
        end
    endtask

    function automatic logic [6:0] exp_vec();
        return {m_serial, m_ws, m_irq, (m_q.size() == 64), (m_q.size() == 0), m_und, m_ovf};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {serial, word_start, rpi_interrupt, full, empty, underrun, overflow};
    endfunction

    // Drive the inputs for one clock, step the model at the edge, return at the falling edge.
    task automatic cycle(input logic ld, input logic [23:0] d, input logic en, input logic clr);
        load = ld; data = d; enable = en; underrun_clr = clr;
        @(posedge clk);
        model_step(ld, d, en, clr);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        load = 0; data = '0; enable = 0; underrun_clr = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (dut_vec() !== 7'b0000100) begin
            bad++;
            $display("FAIL reset_state: got %b want %b (ser,ws,irq,full,empty,und,ovf)", dut_vec(), 7'b0000100);
        end
    endtask

    task automatic test_single_word();
        logic [23:0] bits;
        logic [23:0] starts;
        apply_reset();
        cycle(1, 24'hA5A5A5, 0, 0);
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL single_load: got %b want %b", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 24; i++) begin
            cycle(0, '0, 1, 0);
            bits[i]   = serial;
            starts[i] = word_start;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL single_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (bits !== 24'hA5A5A5) begin
            bad++; $display("FAIL single_stream: got %h want %h", bits, 24'hA5A5A5);
        end
        total++;
        if (starts !== 24'h000001) begin
            bad++; $display("FAIL single_word_start: got %h want %h", starts, 24'h000001);
        end
        cycle(0, '0, 0, 0);
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL single_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] bits;
        logic [47:0] starts;
        apply_reset();
        cycle(1, 24'h000001, 0, 0);
        cycle(1, 24'h800000, 0, 0);
        for (int i = 0; i < 48; i++) begin
            cycle(0, '0, 1, 0);
            bits[i]   = serial;
            starts[i] = word_start;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL b2b_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (bits !== 48'h8000_0000_0001) begin
            bad++; $display("FAIL b2b_stream: got %h want %h", bits, 48'h8000_0000_0001);
        end
        total++;
        if (starts !== 48'h0000_0100_0001) begin
            bad++; $display("FAIL b2b_word_start: got %h want %h", starts, 48'h0000_0100_0001);
        end
    endtask

    task automatic test_underrun();
        apply_reset();
        cycle(0, '0, 1, 0);
        total++;
        if (underrun !== 1'b1 || serial !== 1'b0) begin
            bad++; $display("FAIL underrun_set: got und=%b ser=%b want und=1 ser=0", underrun, serial);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, '0, 1, 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL underrun_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        cycle(0, '0, 0, 0);
        total++;
        if (underrun !== 1'b1) begin
            bad++; $display("FAIL underrun_hold: got %b want 1", underrun);
        end
        cycle(0, '0, 0, 1);
        total++;
        if (underrun !== 1'b0) begin
            bad++; $display("FAIL underrun_clear: got %b want 0", underrun);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] words[65];
        logic [23:0] got;
        apply_reset();
        for (int i = 0; i < 65; i++) begin
            words[i] = 24'($urandom);
            cycle(1, words[i], 0, 0);
            if (i == 63) begin
                total++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    bad++; $display("FAIL ovf_full64: got full=%b ovf=%b want full=1 ovf=0", full, overflow);
                end
            end
        end
        total++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            bad++; $display("FAIL ovf_set: got ovf=%b full=%b want 1 1", overflow, full);
        end
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 24; b++) begin
                cycle(0, '0, 1, 0);
                got[b] = serial;
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++; $display("FAIL ovf_cyc w%0d b%0d: got %b want %b", w, b, dut_vec(), exp_vec());
                end
            end
            total++;
            if (got !== words[w]) begin
                bad++; $display("FAIL ovf_word%0d: got %h want %h", w, got, words[w]);
            end
        end
        cycle(0, '0, 0, 0);
    endtask

    task automatic test_interrupt();
        int rise;
        int guard;
        apply_reset();
        for (int i = 0; i < 64; i++) cycle(1, 24'($urandom), 0, 0);
        rise = 0;
        for (int c = 1; c <= 2000 && rise == 0; c++) begin
            cycle(0, '0, 1, 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL irq_drain c%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
            if (rpi_interrupt === 1'b1) rise = c;
        end
        // Pop 32 lands on enabled edge 1 + 31*24 = 745; the interrupt registers one edge later.
        total++;
        if (rise != 746) begin
            bad++; $display("FAIL irq_rise_cycle: got %0d want 746", rise);
        end
        guard = 0;
        while (full !== 1'b1 && guard < 200) begin
            cycle(1, 24'($urandom), 1, 0);
            guard++;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL irq_refill g%0d: got %b want %b", guard, dut_vec(), exp_vec());
            end
        end
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL irq_refill_timeout: full=%b want 1", full);
        end
        cycle(1, 24'($urandom), 1, 0);
        total++;
        if (rpi_interrupt !== 1'b0 || full !== 1'b1) begin
            bad++; $display("FAIL irq_fall: got irq=%b full=%b want irq=0 full=1", rpi_interrupt, full);
        end
    endtask

    task automatic test_reset_midword();
        apply_reset();
        cycle(1, 24'hFFFFFF, 0, 0);
        // After 11 enabled cycles, bit 10 is on the line.
        for (int i = 0; i < 11; i++) cycle(0, '0, 1, 0);
        total++;
        if (serial !== 1'b1) begin
            bad++; $display("FAIL midword_pre: serial=%b want 1", serial);
        end
        rst_n = 0;
        #1;
        total++;
        if (dut_vec() !== 7'b0000100) begin
            bad++; $display("FAIL midword_async: got %b want %b", dut_vec(), 7'b0000100);
        end
        model_reset();
        #1;
        rst_n = 1;
        cycle(0, '0, 1, 0);
        total++;
        if (underrun !== 1'b1 || serial !== 1'b0) begin
            bad++; $display("FAIL midword_after: und=%b ser=%b want und=1 ser=0", underrun, serial);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, '0, 1, 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL midword_cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom % 3) == 0, 24'($urandom), ($urandom % 10) != 0, ($urandom % 16) == 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_c%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 0;
        load = 0; data = '0; enable = 0; underrun_clr = 0;
        model_reset();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_overflow();
        test_interrupt();
        test_reset_midword();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
